// File: rtl/demux_dispatcher_pkg.sv
// +--------------------------------------------------------------------------+
// | demux_dispatcher_pkg : shared slot state type and one-hot decode helper   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package demux_dispatcher_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int c_MAX_OUT = 32;

  // Out-of-range indices decode to all-zero so a bad index can never raise a valid.
  function automatic logic [c_MAX_OUT-1:0] onehot(input int idx, input int num_out);
    logic [c_MAX_OUT-1:0] w_vec;
    w_vec = '0;
    if (idx >= 0 && idx < num_out) w_vec = c_MAX_OUT'(1) << idx;
    return w_vec;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_onehot.sv
// +--------------------------------------------------------------------------+
// | demux_onehot : destination index plus valid -> one-hot channel vector     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module demux_onehot
  import demux_dispatcher_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int DESTW   = 2
) (
  input  logic [DESTW-1:0]   i_dest,
  input  logic               i_valid,
  output logic [NUM_OUT-1:0] o_onehot
);

  assign o_onehot = i_valid ? NUM_OUT'(onehot(int'(i_dest), NUM_OUT)) : '0;

endmodule

`default_nettype wire

// File: rtl/demux_dispatcher.sv
// +--------------------------------------------------------------------------+
// | demux_dispatcher : 1:N valid/ready demux through one registered slot,     |
// | directed or round-robin destination, counted drop of bad indices.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module demux_dispatcher
  import demux_dispatcher_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int DW      = 8,
  parameter int SW      = 2,
  parameter int CW      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [SW-1:0]      in_sel,
  input  logic               rr_mode,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DW-1:0]      out_data,
  output logic               drop_pulse,
  output logic [CW-1:0]      drop_cnt
);

  localparam int              DESTW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [DESTW-1:0] c_LAST    = DESTW'(NUM_OUT - 1);
  localparam logic [CW-1:0]    c_CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DW-1:0]    r_data;
  logic [DESTW-1:0] r_dest;
  logic             r_from_rr;
  logic [DESTW-1:0] r_rr_ptr;
  logic [DESTW-1:0] w_rr_ptr_inc;
  logic [DESTW-1:0] w_rr_ptr_cur;
  logic             r_drop_pulse;
  logic [CW-1:0]    r_drop_cnt;
  logic             w_full;
  logic             w_dest_ready;
  logic             w_drain;
  logic             w_accept;
  logic             w_drop;
  logic             w_store;

  assign w_full       = (r_state == FULL);
  assign w_dest_ready = out_ready[r_dest];
  assign w_drain      = w_full & w_dest_ready;
  assign in_ready     = rst_n & (~w_full | w_dest_ready);
  assign w_accept     = in_valid & in_ready;
  assign w_drop       = w_accept & ~rr_mode & (int'(in_sel) >= NUM_OUT);
  assign w_store      = w_accept & ~w_drop;

  // A round-robin beat accepted in the same cycle its predecessor drains must
  // see the already-advanced pointer, otherwise back-to-back beats collide.
  assign w_rr_ptr_inc = (r_rr_ptr == c_LAST) ? '0 : r_rr_ptr + DESTW'(1);
  assign w_rr_ptr_cur = (w_drain & r_from_rr) ? w_rr_ptr_inc : r_rr_ptr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_store) w_state_nxt = FULL;
      FULL:    if (w_drain & ~w_store) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_dest       <= '0;
      r_from_rr    <= 1'b0;
      r_rr_ptr     <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_rr_ptr     <= w_rr_ptr_cur;
      r_drop_pulse <= w_drop;
      if (w_drop && r_drop_cnt != c_CNT_MAX) r_drop_cnt <= r_drop_cnt + CW'(1);
      if (w_store) begin
        r_data    <= in_data;
        r_dest    <= rr_mode ? w_rr_ptr_cur : DESTW'(in_sel);
        r_from_rr <= rr_mode;
      end
    end
  end

  demux_onehot #(
    .NUM_OUT (NUM_OUT),
    .DESTW   (DESTW)
  ) u_onehot (
    .i_dest   (r_dest),
    .i_valid  (w_full),
    .o_onehot (out_valid)
  );

  assign out_data   = r_data;
  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_demux_dispatcher.sv
// +--------------------------------------------------------------------------+
// | tb_demux_dispatcher : 4-channel and 3-channel instances on shared stimulus|
// | compared every cycle against a slot/queue model; directed + random.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_demux_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       rr_mode;
  logic [3:0] out_ready;

  logic       ir0, dp0, ir1, dp1;
  logic [3:0] ov0;
  logic [2:0] ov1;
  logic [7:0] od0, dc0, od1, dc1;

  int n_checks = 0;
  int n_err    = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  demux_dispatcher #(.NUM_OUT(4), .DW(8), .SW(2), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_sel(in_sel), .rr_mode(rr_mode),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .drop_pulse(dp0), .drop_cnt(dc0)
  );

  demux_dispatcher #(.NUM_OUT(3), .DW(8), .SW(2), .CW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_sel(in_sel), .rr_mode(rr_mode),
    .out_valid(ov1), .out_ready(out_ready[2:0]), .out_data(od1),
    .drop_pulse(dp1), .drop_cnt(dc1)
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst%0d] t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: at most one beat in flight per instance; the k-th
  // round-robin beat since reset goes to channel k mod N.
  int         nout [2] = '{4, 3};
  logic       mv   [2];
  logic [7:0] md   [2];
  int         mdst [2];
  int         mrr  [2];
  int         mdc  [2];
  logic       mdp  [2];

  always @(posedge clk) begin
    logic drn, rdy;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mv[k] = 1'b0; mdst[k] = 0; mrr[k] = 0; mdc[k] = 0; mdp[k] = 1'b0;
      end else begin
        drn    = mv[k] && out_ready[mdst[k]];
        rdy    = !mv[k] || drn;
        mdp[k] = 1'b0;
        if (drn) mv[k] = 1'b0;
        if (in_valid && rdy) begin
          if (rr_mode) begin
            mv[k] = 1'b1; md[k] = in_data; mdst[k] = mrr[k] % nout[k]; mrr[k]++;
          end else if (int'(in_sel) < nout[k]) begin
            mv[k] = 1'b1; md[k] = in_data; mdst[k] = int'(in_sel);
          end else begin
            mdp[k] = 1'b1;
            if (mdc[k] < 255) mdc[k]++;
          end
        end
      end
    end
  end

  logic [3:0] ovx [2];
  logic [7:0] odx [2];
  logic [7:0] dcx [2];
  logic       irx [2];
  logic       dpx [2];
  always_comb begin
    ovx[0] = ov0; ovx[1] = {1'b0, ov1};
    odx[0] = od0; odx[1] = od1;
    dcx[0] = dc0; dcx[1] = dc1;
    irx[0] = ir0; irx[1] = ir1;
    dpx[0] = dp0; dpx[1] = dp1;
  end

  always @(negedge clk) begin
    logic [3:0] ev;
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        ev = mv[k] ? (4'b0001 << mdst[k]) : 4'b0000;
        chk("out_valid", k, ovx[k], ev);
        if (mv[k]) chk("out_data", k, odx[k], md[k]);
        chk("in_ready", k, irx[k], rst_n && (!mv[k] || out_ready[mdst[k]]));
        chk("drop_pulse", k, dpx[k], mdp[k]);
        chk("drop_cnt", k, dcx[k], mdc[k]);
        chk("onehot0", k, $onehot0(ovx[k]), 1);
      end
    end
  end

  task automatic beat(input logic v, input logic [7:0] d, input logic [1:0] s,
                      input logic rr, input logic [3:0] ordy);
    in_valid = v; in_data = d; in_sel = s; rr_mode = rr; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  logic [3:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; rr_mode = 1'b0; out_ready = 4'hF;
    @(posedge clk); #1;
    checking = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 0, ov0, 4'b0000);
    chk("rst_out_data", 0, od0, 8'h00);
    chk("rst_drop_cnt", 0, dc0, 8'h00);
    chk("rst_in_ready", 0, ir0, 1'b0);
    rst_n = 1'b1;

    // directed, all ready
    beat(1'b1, 8'hA5, 2'd2, 1'b0, 4'hF);
    chk("dir_valid", 0, ov0, 4'b0100);
    chk("dir_data", 0, od0, 8'hA5);
    for (int s = 0; s < 4; s++) begin
      beat(1'b1, 8'(s + 1), 2'(s), 1'b0, 4'hF);
      chk("stream_valid", 0, ov0, 4'b0001 << s);
      chk("stream_in_ready", 0, ir0, 1'b1);
    end

    // backpressure on the held channel only
    beat(1'b1, 8'h55, 2'd1, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 8'h66, 2'd0, 1'b0, 4'b1101);
      chk("bp_valid", 0, ov0, 4'b0010);
      chk("bp_data", 0, od0, 8'h55);
    end
    chk("bp_in_ready", 0, ir0, 1'b0);
    beat(1'b1, 8'h66, 2'd0, 1'b0, 4'hF);
    chk("bp_next_valid", 0, ov0, 4'b0001);
    chk("bp_next_data", 0, od0, 8'h66);

    // round-robin, then a directed beat mid-stream
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, 8'(10 + i), 2'd0, 1'b1, 4'hF);
      chk("rr_dest", 0, ov0, rr_exp[i]);
    end
    beat(1'b1, 8'h20, 2'd3, 1'b0, 4'hF);
    chk("rr_directed", 0, ov0, 4'b1000);
    beat(1'b1, 8'h21, 2'd0, 1'b1, 4'hF);
    chk("rr_resume", 0, ov0, 4'b0100);
    chk("rr_resume_data", 0, od0, 8'h21);
    beat(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // reset while a beat is held
    beat(1'b1, 8'h99, 2'd2, 1'b0, 4'h0);
    beat(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
    rst_n = 1'b0;
    beat(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
    chk("mid_rst_valid", 0, ov0, 4'b0000);
    chk("mid_rst_data", 0, od0, 8'h00);
    chk("mid_rst_drop_cnt", 1, dc1, 8'h00);
    chk("mid_rst_in_ready", 0, ir0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
      chk("post_rst_idle", 0, ov0, 4'b0000);
    end
    beat(1'b1, 8'h30, 2'd0, 1'b1, 4'hF);
    chk("post_rst_rr0", 0, ov0, 4'b0001);
    chk("post_rst_rr0", 1, ov1, 3'b001);

    // drop on the 3-channel instance
    beat(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    beat(1'b1, 8'h77, 2'd3, 1'b0, 4'hF);
    chk("drop_valid", 1, ov1, 3'b000);
    chk("drop_pulse", 1, dp1, 1'b1);
    chk("drop_cnt1", 1, dc1, 8'd1);
    beat(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    chk("drop_pulse_end", 1, dp1, 1'b0);
    for (int i = 0; i < 299; i++) beat(1'b1, 8'(i), 2'd3, 1'b0, 4'hF);
    chk("drop_saturate", 1, dc1, 8'd255);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      beat(1'($urandom_range(0, 2) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) == 0),
           {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
    end
    rst_n = 1'b1;
    beat(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    @(negedge clk);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
